// File: rtl/spi_flash_responder.sv
// SPI flash read-only responder: serves FAST_READ (0x0B) from a word-wide
// memory with single-cycle read latency, and recognises release-from-deep-power-down.
module spi_flash_responder #(
    parameter int         DUMMY_CLKS = 8,
    parameter logic [7:0] FAST_RD    = 8'h0b,
    parameter logic [7:0] RLS_DPD    = 8'hab
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SPI_CSS,
    input  logic        SPI_CLK,
    input  logic        SPI_MOSI,
    output logic        SPI_MISO,
    output logic        o_rd_en,
    output logic [21:0] o_rd_addr,
    input  logic [31:0] i_rd_data,
    output logic        o_wake,
    output logic        o_cmd_err,
    output logic        o_busy
);

    localparam int DCW = (DUMMY_CLKS < 2) ? 1 : $clog2(DUMMY_CLKS + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_IGNORE
    } state_t;

    // Wire order within a word is byte 0 first; swapping lets the shifter run MSB-first.
    function automatic logic [31:0] byte_swap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    logic [2:0] pin_vec;
    logic [2:0] meta_reg;
    logic [2:0] sync_reg;
    logic [1:0] settle_reg;
    logic       armed_reg;
    logic       sck_prev_reg;
    logic       css_s, sck_s, mosi_s;
    logic       sck_rise, sck_fall;

    state_t         state_reg, state_next;
    logic [4:0]     bit_cnt_reg, bit_cnt_next;
    logic [22:0]    shift_in_reg, shift_in_next;
    logic [DCW-1:0] dummy_cnt_reg, dummy_cnt_next;
    logic [31:0]    sh_reg, sh_next;
    logic [5:0]     bits_left_reg, bits_left_next;
    logic [31:0]    buf_reg, buf_next;
    logic [21:0]    word_addr_reg, word_addr_next;
    logic [1:0]     byte_off_reg, byte_off_next;
    logic           first_reg, first_next;
    logic           data_vld_reg, data_vld_next;
    logic           miso_reg, miso_next;
    logic           rd_en_reg, rd_en_next;
    logic [21:0]    rd_addr_reg, rd_addr_next;
    logic           wake_reg, wake_next;
    logic           cmd_err_reg, cmd_err_next;

    logic [7:0]  cmd_byte;
    logic [23:0] addr_in;
    logic [31:0] buf_swapped;
    logic        shift_now;

    assign pin_vec = {SPI_CSS, SPI_CLK, SPI_MOSI};
    assign css_s   = sync_reg[2];
    assign sck_s   = sync_reg[1];
    assign mosi_s  = sync_reg[0];

    assign sck_rise    = sck_s & ~sck_prev_reg;
    assign sck_fall    = ~sck_s & sck_prev_reg;
    assign cmd_byte    = {shift_in_reg[6:0], mosi_s};
    assign addr_in     = {shift_in_reg, mosi_s};
    assign buf_swapped = byte_swap(buf_reg);

    // Synchronisers idle high; armed only once a real CSS-high has propagated,
    // so a transaction already in progress at reset release is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_reg     <= 3'b111;
            sync_reg     <= 3'b111;
            settle_reg   <= 2'b00;
            armed_reg    <= 1'b0;
            sck_prev_reg <= 1'b1;
        end else begin
            meta_reg     <= pin_vec;
            sync_reg     <= meta_reg;
            settle_reg   <= {settle_reg[0], 1'b1};
            armed_reg    <= armed_reg | (settle_reg[1] & css_s);
            sck_prev_reg <= sck_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            bit_cnt_reg   <= '0;
            shift_in_reg  <= '0;
            dummy_cnt_reg <= '0;
            sh_reg        <= '0;
            bits_left_reg <= '0;
            buf_reg       <= '0;
            word_addr_reg <= '0;
            byte_off_reg  <= '0;
            first_reg     <= 1'b0;
            data_vld_reg  <= 1'b0;
            miso_reg      <= 1'b1;
            rd_en_reg     <= 1'b0;
            rd_addr_reg   <= '0;
            wake_reg      <= 1'b0;
            cmd_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_in_reg  <= shift_in_next;
            dummy_cnt_reg <= dummy_cnt_next;
            sh_reg        <= sh_next;
            bits_left_reg <= bits_left_next;
            buf_reg       <= buf_next;
            word_addr_reg <= word_addr_next;
            byte_off_reg  <= byte_off_next;
            first_reg     <= first_next;
            data_vld_reg  <= data_vld_next;
            miso_reg      <= miso_next;
            rd_en_reg     <= rd_en_next;
            rd_addr_reg   <= rd_addr_next;
            wake_reg      <= wake_next;
            cmd_err_reg   <= cmd_err_next;
        end
    end

    // CSS high overrides any SCK edge seen in the same cycle.
    always_comb begin
        state_next = state_reg;
        if (state_reg == ST_IDLE) begin
            if (armed_reg && !css_s) state_next = ST_CMD;
        end else if (css_s) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_CMD:   if (sck_rise && bit_cnt_reg == 5'd7)
                              state_next = (cmd_byte == FAST_RD) ? ST_ADDR : ST_IGNORE;
                ST_ADDR:  if (sck_rise && bit_cnt_reg == 5'd23) state_next = ST_DUMMY;
                ST_DUMMY: if (sck_fall && dummy_cnt_reg == '0) state_next = ST_DATA;
                default:  ;
            endcase
        end
    end

    always_comb begin
        bit_cnt_next   = bit_cnt_reg;
        shift_in_next  = shift_in_reg;
        dummy_cnt_next = dummy_cnt_reg;
        sh_next        = sh_reg;
        bits_left_next = bits_left_reg;
        buf_next       = buf_reg;
        word_addr_next = word_addr_reg;
        byte_off_next  = byte_off_reg;
        first_next     = first_reg;
        data_vld_next  = 1'b0;
        miso_next      = miso_reg;
        rd_en_next     = 1'b0;
        rd_addr_next   = rd_addr_reg;
        wake_next      = 1'b0;
        cmd_err_next   = 1'b0;
        shift_now      = 1'b0;

        if (state_reg == ST_IDLE || css_s) begin
            miso_next   = 1'b1;
            bit_cnt_next = '0;
            first_next  = 1'b0;
        end else begin
            data_vld_next = rd_en_reg;
            case (state_reg)
                ST_CMD: begin
                    miso_next = 1'b1;
                    if (sck_rise) begin
                        shift_in_next = {shift_in_reg[21:0], mosi_s};
                        bit_cnt_next  = bit_cnt_reg + 5'd1;
                        if (bit_cnt_reg == 5'd7) begin
                            bit_cnt_next = '0;
                            if (cmd_byte == RLS_DPD)      wake_next    = 1'b1;
                            else if (cmd_byte != FAST_RD) cmd_err_next = 1'b1;
                        end
                    end
                end
                ST_ADDR: begin
                    miso_next = 1'b1;
                    if (sck_rise) begin
                        shift_in_next = {shift_in_reg[21:0], mosi_s};
                        bit_cnt_next  = bit_cnt_reg + 5'd1;
                        if (bit_cnt_reg == 5'd23) begin
                            bit_cnt_next   = '0;
                            rd_en_next     = 1'b1;
                            rd_addr_next   = addr_in[23:2];
                            word_addr_next = addr_in[23:2] + 22'd1;
                            byte_off_next  = addr_in[1:0];
                            dummy_cnt_next = DCW'(DUMMY_CLKS);
                            first_next     = 1'b1;
                        end
                    end
                end
                ST_DUMMY, ST_DATA: begin
                    // First word goes straight to the shifter; later words land in the prefetch buffer.
                    if (data_vld_reg) begin
                        if (first_reg) begin
                            first_next     = 1'b0;
                            sh_next        = byte_swap(i_rd_data) << {byte_off_reg, 3'b000};
                            bits_left_next = 6'd32 - {1'b0, byte_off_reg, 3'b000};
                            rd_en_next     = 1'b1;
                            rd_addr_next   = word_addr_reg;
                            word_addr_next = word_addr_reg + 22'd1;
                        end else begin
                            buf_next = i_rd_data;
                        end
                    end
                    if (state_reg == ST_DUMMY) begin
                        miso_next = 1'b1;
                        if (sck_rise && dummy_cnt_reg != '0)
                            dummy_cnt_next = dummy_cnt_reg - DCW'(1);
                        shift_now = sck_fall && (dummy_cnt_reg == '0);
                    end else begin
                        shift_now = sck_fall;
                    end
                    if (shift_now) begin
                        if (bits_left_reg == 6'd0) begin
                            miso_next      = buf_swapped[31];
                            sh_next        = buf_swapped << 1;
                            bits_left_next = 6'd31;
                            rd_en_next     = 1'b1;
                            rd_addr_next   = word_addr_reg;
                            word_addr_next = word_addr_reg + 22'd1;
                        end else begin
                            miso_next      = sh_reg[31];
                            sh_next        = sh_reg << 1;
                            bits_left_next = bits_left_reg - 6'd1;
                        end
                    end
                end
                default: miso_next = 1'b1;
            endcase
        end
    end

    assign SPI_MISO  = miso_reg;
    assign o_rd_en   = rd_en_reg;
    assign o_rd_addr = rd_addr_reg;
    assign o_wake    = wake_reg;
    assign o_cmd_err = cmd_err_reg;
    assign o_busy    = (state_reg != ST_IDLE);

endmodule
